// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller: one host access at a time, fixed-length strobe
// windows, every pad-side output driven from a register.
module sram_ctrl #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_CYC = 3,
    parameter int unsigned WR_CYC = 3,
    parameter int unsigned TA_CYC = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_dq_i,
    output logic [DATA_W-1:0] ram_dq_o,
    output logic [DATA_W-1:0] ram_dq_t,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n
);
    localparam int unsigned MAX_RW  = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
    localparam int unsigned MAX_CYC = (MAX_RW > TA_CYC) ? MAX_RW : TA_CYC;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // Counter is loaded with (length - 1) and stops at zero.
    localparam logic [CNT_W-1:0] RD_LD = CNT_W'(RD_CYC - 1);
    localparam logic [CNT_W-1:0] WR_LD = CNT_W'(WR_CYC - 1);
    localparam logic [CNT_W-1:0] TA_LD = CNT_W'((TA_CYC > 0) ? (TA_CYC - 1) : 0);

    typedef enum logic [2:0] {IDLE, READ, WRITE, WREC, TURN} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [ADDR_W-1:0]  addr_nxt;
    logic [DATA_W-1:0]  dq_o_nxt, dq_t_nxt, rdata_nxt;
    logic               ce_nxt, oe_nxt, we_nxt, rsp_valid_nxt, ready_nxt;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = (cnt != '0) ? (cnt - CNT_W'(1)) : cnt;
        addr_nxt      = ram_addr;
        dq_o_nxt      = ram_dq_o;
        dq_t_nxt      = ram_dq_t;
        ce_nxt        = ram_ce_n;
        oe_nxt        = ram_oe_n;
        we_nxt        = ram_we_n;
        rsp_valid_nxt = 1'b0;
        rdata_nxt     = rsp_rdata;

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    addr_nxt = req_addr;
                    ce_nxt   = 1'b0;
                    if (req_we) begin
                        state_nxt = WRITE;
                        cnt_nxt   = WR_LD;
                        we_nxt    = 1'b0;
                        dq_t_nxt  = '0;
                        dq_o_nxt  = req_wdata;
                    end else begin
                        state_nxt = READ;
                        cnt_nxt   = RD_LD;
                        oe_nxt    = 1'b0;
                    end
                end
            end
            READ: begin
                if (cnt == '0) begin
                    state_nxt     = IDLE;
                    ce_nxt        = 1'b1;
                    oe_nxt        = 1'b1;
                    rsp_valid_nxt = 1'b1;
                    rdata_nxt     = ram_dq_i;
                end
            end
            WRITE: begin
                // WE rises first; address and data stay put for the hold cycle.
                if (cnt == '0) begin
                    state_nxt = WREC;
                    we_nxt    = 1'b1;
                end
            end
            WREC: begin
                ce_nxt   = 1'b1;
                dq_t_nxt = '1;
                if (TA_CYC == 0) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = TURN;
                    cnt_nxt   = TA_LD;
                end
            end
            TURN: begin
                if (cnt == '0) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                ce_nxt    = 1'b1;
                oe_nxt    = 1'b1;
                we_nxt    = 1'b1;
                dq_t_nxt  = '1;
            end
        endcase

        ready_nxt = (state_nxt == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            ram_addr  <= '0;
            ram_dq_o  <= '0;
            ram_dq_t  <= '1;
            ram_ce_n  <= 1'b1;
            ram_oe_n  <= 1'b1;
            ram_we_n  <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            req_ready <= ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rdata_nxt;
            ram_addr  <= addr_nxt;
            ram_dq_o  <= dq_o_nxt;
            ram_dq_t  <= dq_t_nxt;
            ram_ce_n  <= ce_nxt;
            ram_oe_n  <= oe_nxt;
            ram_we_n  <= we_nxt;
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: default build exercised with directed vectors and corner
// sequences, a fast build (16-bit, single-cycle) with random traffic vs a model.
module tb_sram_ctrl;
    localparam int unsigned A0 = 19, D0 = 8,  RD0 = 3, WR0 = 3, TA0 = 1;
    localparam int unsigned A1 = 18, D1 = 16, RD1 = 1, WR1 = 1, TA1 = 0;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT 0 (defaults) ----------------
    logic          r0_valid = 1'b0, r0_we = 1'b0;
    logic [A0-1:0] r0_addr  = '0;
    logic [D0-1:0] r0_wdata = '0;
    logic          r0_ready, s0_valid, m0_ce_n, m0_oe_n, m0_we_n;
    logic [D0-1:0] s0_rdata, m0_dq_o, m0_dq_t;
    logic [D0-1:0] m0_dq_i = '0;
    logic [A0-1:0] m0_addr;

    sram_ctrl #(.ADDR_W(A0), .DATA_W(D0), .RD_CYC(RD0), .WR_CYC(WR0), .TA_CYC(TA0)) u0 (
        .clk(clk), .reset(reset), .req_valid(r0_valid), .req_ready(r0_ready),
        .req_we(r0_we), .req_addr(r0_addr), .req_wdata(r0_wdata),
        .rsp_valid(s0_valid), .rsp_rdata(s0_rdata), .ram_addr(m0_addr),
        .ram_dq_i(m0_dq_i), .ram_dq_o(m0_dq_o), .ram_dq_t(m0_dq_t),
        .ram_ce_n(m0_ce_n), .ram_oe_n(m0_oe_n), .ram_we_n(m0_we_n));

    // ---------------- DUT 1 (fast, wide) ----------------
    logic          r1_valid = 1'b0, r1_we = 1'b0;
    logic [A1-1:0] r1_addr  = '0;
    logic [D1-1:0] r1_wdata = '0;
    logic          r1_ready, s1_valid, m1_ce_n, m1_oe_n, m1_we_n;
    logic [D1-1:0] s1_rdata, m1_dq_o, m1_dq_t;
    logic [D1-1:0] m1_dq_i = '0;
    logic [A1-1:0] m1_addr;

    sram_ctrl #(.ADDR_W(A1), .DATA_W(D1), .RD_CYC(RD1), .WR_CYC(WR1), .TA_CYC(TA1)) u1 (
        .clk(clk), .reset(reset), .req_valid(r1_valid), .req_ready(r1_ready),
        .req_we(r1_we), .req_addr(r1_addr), .req_wdata(r1_wdata),
        .rsp_valid(s1_valid), .rsp_rdata(s1_rdata), .ram_addr(m1_addr),
        .ram_dq_i(m1_dq_i), .ram_dq_o(m1_dq_o), .ram_dq_t(m1_dq_t),
        .ram_ce_n(m1_ce_n), .ram_oe_n(m1_oe_n), .ram_we_n(m1_we_n));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Power-up contents of the behavioural SRAMs
    function automatic logic [D0-1:0] init0(input logic [A0-1:0] a);
        return D0'(a) ^ 8'h5A;
    endfunction
    function automatic logic [D1-1:0] init1(input logic [A1-1:0] a);
        return D1'(a) ^ 16'hC3A5;
    endfunction

    // Behavioural SRAMs behind the IOBUFs; data bus is noise unless OE is low
    logic [D0-1:0] sram0 [logic [A0-1:0]];
    logic [D1-1:0] sram1 [logic [A1-1:0]];
    always @(posedge clk) begin
        if (!m0_ce_n && !m0_we_n && m0_dq_t == '0) sram0[m0_addr] = m0_dq_o;
        if (!m1_ce_n && !m1_we_n && m1_dq_t == '0) sram1[m1_addr] = m1_dq_o;
    end
    always @(negedge clk) begin
        if (!m0_ce_n && !m0_oe_n)
            m0_dq_i <= sram0.exists(m0_addr) ? sram0[m0_addr] : init0(m0_addr);
        else
            m0_dq_i <= D0'($urandom);
        if (!m1_ce_n && !m1_oe_n)
            m1_dq_i <= sram1.exists(m1_addr) ? sram1[m1_addr] : init1(m1_addr);
        else
            m1_dq_i <= D1'($urandom);
    end

    // Reference memories: updated when the bench issues a write
    logic [D0-1:0] ref0 [logic [A0-1:0]];
    logic [D1-1:0] ref1 [logic [A1-1:0]];
    function automatic logic [D0-1:0] ref_rd0(input logic [A0-1:0] a);
        return ref0.exists(a) ? ref0[a] : init0(a);
    endfunction
    function automatic logic [D1-1:0] ref_rd1(input logic [A1-1:0] a);
        return ref1.exists(a) ? ref1[a] : init1(a);
    endfunction

    // Pad invariants, checked every cycle on both instances
    logic          rst_seen = 1'b1;
    logic          p_ready0 = 1'b1, p_ready1 = 1'b1;
    logic [A0-1:0] p_addr0  = '0;
    logic [A1-1:0] p_addr1  = '0;
    logic [2:0]    inv0, inv1;
    always @(posedge clk) rst_seen <= reset;
    always @(negedge clk) begin
        inv0 = {(m0_addr != p_addr0) && !p_ready0 && !rst_seen,
                (m0_dq_t != '1) && !m0_oe_n,
                !m0_oe_n && !m0_we_n};
        inv1 = {(m1_addr != p_addr1) && !p_ready1 && !rst_seen,
                (m1_dq_t != '1) && !m1_oe_n,
                !m1_oe_n && !m1_we_n};
        chk("invariant0", 32'(inv0), 32'd0);
        chk("invariant1", 32'(inv1), 32'd0);
        p_addr0  = m0_addr;
        p_addr1  = m1_addr;
        p_ready0 = r0_ready;
        p_ready1 = r1_ready;
    end

    // Random-traffic scoreboard for DUT 1
    typedef struct { logic [D1-1:0] d; int unsigned c; } exp_t;
    exp_t q1[$];
    exp_t e1;
    always @(negedge clk) begin
        if (s1_valid) begin
            if (q1.size() == 0) begin
                chk("rnd_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                chk("rnd_data", 32'(s1_rdata), 32'(e1.d));
                chk("rnd_latency", 32'(cyc - e1.c), 32'(RD1 + 1));
            end
        end
    end

    // One complete access on DUT 0, observed cycle by cycle from the accept edge
    task automatic op0(input logic we, input logic [A0-1:0] a, input logic [D0-1:0] wd,
                       output logic [D0-1:0] rd, output int lat, output int we_low,
                       output int oe_low, output int dqt0, output int nrsp, output int done);
        int guard;
        guard = 0; rd = '0; lat = 0; we_low = 0; oe_low = 0; dqt0 = 0; nrsp = 0; done = 0;
        @(negedge clk);
        while (!r0_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("op_ready", 32'(r0_ready), 32'd1);
        r0_valid = 1'b1; r0_we = we; r0_addr = a; r0_wdata = wd;
        if (we) ref0[a] = wd;
        @(negedge clk);
        r0_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (!m0_we_n) we_low++;
            if (!m0_oe_n) oe_low++;
            if (m0_dq_t == '0) dqt0++;
            if (s0_valid) begin
                nrsp++;
                lat = c;
                rd  = s0_rdata;
            end
            if (r0_ready) begin
                done = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic          we;
        logic [A0-1:0] addr;
        logic [D0-1:0] wdata;
        logic [D0-1:0] exp_rd;
    } vec_t;
    vec_t vt[9];

    logic [D0-1:0] rd;
    int lat, we_low, oe_low, dqt0, nrsp, done;
    int n_acc, n_rsp, seen_we, oe_fell, gap, rd_acc, got, guard, gapc;
    int unsigned last_acc;
    logic [A0-1:0] qa[4];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        vt[0] = '{1'b1, 19'h12345, 8'hA5, 8'h00};
        vt[1] = '{1'b0, 19'h12345, 8'h00, 8'hA5};
        vt[2] = '{1'b1, 19'h00000, 8'h3C, 8'h00};
        vt[3] = '{1'b1, 19'h7FFFF, 8'hC3, 8'h00};
        vt[4] = '{1'b0, 19'h7FFFF, 8'h00, 8'hC3};
        vt[5] = '{1'b0, 19'h00000, 8'h00, 8'h3C};
        vt[6] = '{1'b0, 19'h00777, 8'h00, 8'h2D};
        vt[7] = '{1'b1, 19'h12345, 8'h5A, 8'h00};
        vt[8] = '{1'b0, 19'h12345, 8'h00, 8'h5A};

        // Reset state on both instances
        repeat (3) @(negedge clk);
        chk("rst_ready0", 32'(r0_ready), 32'd0);
        chk("rst_rsp_valid0", 32'(s0_valid), 32'd0);
        chk("rst_rdata0", 32'(s0_rdata), 32'd0);
        chk("rst_addr0", 32'(m0_addr), 32'd0);
        chk("rst_dq_o0", 32'(m0_dq_o), 32'd0);
        chk("rst_dq_t0", 32'(m0_dq_t), 32'hFF);
        chk("rst_strobes0", 32'({m0_ce_n, m0_oe_n, m0_we_n}), 32'd7);
        chk("rst_ready1", 32'(r1_ready), 32'd0);
        chk("rst_dq_t1", 32'(m1_dq_t), 32'hFFFF);
        chk("rst_strobes1", 32'({m1_ce_n, m1_oe_n, m1_we_n}), 32'd7);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst0", 32'(r0_ready), 32'd1);
        chk("ready_after_rst1", 32'(r1_ready), 32'd1);

        // Directed vector table on the default build
        for (int i = 0; i < 9; i++) begin
            op0(vt[i].we, vt[i].addr, vt[i].wdata, rd, lat, we_low, oe_low, dqt0, nrsp, done);
            if (vt[i].we) begin
                chk("wr_we_low_cycles", 32'(we_low), 32'(WR0));
                chk("wr_dq_driven_cycles", 32'(dqt0), 32'(WR0 + 1));
                chk("wr_oe_low_cycles", 32'(oe_low), 32'd0);
                chk("wr_no_rsp", 32'(nrsp), 32'd0);
                chk("wr_back_to_idle", 32'(done), 32'(WR0 + 2 + TA0));
            end else begin
                chk("rd_oe_low_cycles", 32'(oe_low), 32'(RD0));
                chk("rd_we_low_cycles", 32'(we_low), 32'd0);
                chk("rd_dq_driven_cycles", 32'(dqt0), 32'd0);
                chk("rd_rsp_count", 32'(nrsp), 32'd1);
                chk("rd_rsp_cycle", 32'(lat), 32'(RD0 + 1));
                chk("rd_ready_with_rsp", 32'(done), 32'(RD0 + 1));
                chk("rd_data", 32'(rd), 32'(vt[i].exp_rd));
            end
        end

        // Back-to-back reads with req_valid held high
        qa[0] = 19'h12345; qa[1] = 19'h7FFFF; qa[2] = 19'h00000; qa[3] = 19'h01234;
        n_acc = 0; n_rsp = 0; last_acc = 0;
        @(negedge clk);
        r0_valid = 1'b1; r0_we = 1'b0;
        for (int c = 0; c < 40 && n_rsp < 4; c++) begin
            if (s0_valid) begin
                chk("queued_rd_data", 32'(s0_rdata), 32'(ref_rd0(qa[n_rsp])));
                n_rsp++;
            end
            if (n_acc < 4) r0_addr = qa[n_acc];
            else r0_valid = 1'b0;
            if (r0_valid && r0_ready) begin
                if (n_acc > 0) chk("queued_accept_spacing", 32'(cyc - last_acc), 32'(RD0 + 1));
                last_acc = cyc;
                n_acc++;
            end
            @(negedge clk);
        end
        r0_valid = 1'b0;
        chk("queued_accepts", 32'(n_acc), 32'd4);
        chk("queued_rsps", 32'(n_rsp), 32'd4);

        // Write immediately followed by a read: bus must idle between WE and OE
        op0(1'b0, 19'h00001, 8'h00, rd, lat, we_low, oe_low, dqt0, nrsp, done);
        r0_valid = 1'b1; r0_we = 1'b1; r0_addr = 19'h2BEEF; r0_wdata = 8'h77;
        ref0[19'h2BEEF] = 8'h77;
        @(negedge clk);
        r0_we = 1'b0;
        seen_we = 0; oe_fell = 0; gap = 0; rd_acc = 0; got = 0;
        for (int c = 0; c < 30 && got == 0; c++) begin
            if (rd_acc != 0) r0_valid = 1'b0;
            if (!m0_we_n) seen_we = 1;
            if (!m0_oe_n) oe_fell = 1;
            if (seen_we != 0 && m0_we_n && oe_fell == 0 && m0_ce_n && m0_dq_t == '1) gap++;
            if (r0_valid && r0_ready) rd_acc = 1;
            if (s0_valid) begin
                got = 1;
                chk("wr_then_rd_data", 32'(s0_rdata), 32'(ref_rd0(19'h2BEEF)));
            end
            if (got == 0) @(negedge clk);
        end
        r0_valid = 1'b0;
        chk("wr_then_rd_got_rsp", 32'(got), 32'd1);
        chk("turnaround_gap", 32'(gap >= 1), 32'd1);

        // Reset during the second WRITE cycle aborts the access
        @(negedge clk);
        guard = 0;
        while (!r0_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        r0_valid = 1'b1; r0_we = 1'b1; r0_addr = 19'h00ABC; r0_wdata = 8'h99;
        @(negedge clk);
        r0_valid = 1'b0;
        chk("abort_write_cycle1", 32'(m0_we_n), 32'd0);
        @(negedge clk);
        chk("abort_write_cycle2", 32'(m0_we_n), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_we_n", 32'(m0_we_n), 32'd1);
        chk("abort_ce_n", 32'(m0_ce_n), 32'd1);
        chk("abort_dq_t", 32'(m0_dq_t), 32'hFF);
        chk("abort_rsp_valid", 32'(s0_valid), 32'd0);
        reset = 1'b0;
        gapc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (s0_valid) gapc++;
        end
        chk("abort_no_rsp", 32'(gapc), 32'd0);
        op0(1'b0, 19'h00DEF, 8'h00, rd, lat, we_low, oe_low, dqt0, nrsp, done);
        chk("abort_then_rd_data", 32'(rd), 32'(ref_rd0(19'h00DEF)));
        chk("abort_then_rd_rsp", 32'(nrsp), 32'd1);

        // Random traffic on the fast build against the reference model
        @(negedge clk);
        for (int n = 0; n < 1000; n++) begin
            gapc = int'($urandom_range(0, 3));
            repeat (gapc) @(negedge clk);
            r1_valid = 1'b1;
            r1_we    = 1'($urandom_range(0, 1));
            r1_addr  = A1'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) r1_addr[A1-1:A1-4] = 4'hF;
            r1_wdata = D1'($urandom);
            guard = 0;
            while (!r1_ready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            chk("rnd_accept", 32'(r1_ready), 32'd1);
            if (r1_we) ref1[r1_addr] = r1_wdata;
            else q1.push_back('{d: ref_rd1(r1_addr), c: cyc});
            @(negedge clk);
            r1_valid = 1'b0;
        end
        repeat (6) @(negedge clk);
        chk("rnd_drain", 32'(q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  ADDR_W  19  SRAM address width
  DATA_W  8  SRAM data width; one tristate lane per bit
  RD_CYC  3  cycles OE held low before data sampled; >=1
  WR_CYC  3  cycles WE held low; >=1
  TA_CYC  1  bus-turnaround idle cycles after a write; >=0
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single clock; all logic on rising edge
  reset  in  1  synchronous, active-high reset
  req_valid  in  1  host request present
  req_ready  out  1  controller accepts a request this cycle
  req_we  in  1  1 = write, 0 = read
  req_addr  in  ADDR_W  access address
  req_wdata  in  DATA_W  write data
  rsp_valid  out  1  one-cycle pulse; rsp_rdata valid
  rsp_rdata  out  DATA_W  read data
  ram_addr  out  ADDR_W  SRAM address
  ram_dq_i  in  DATA_W  SRAM data from IOBUF O
  ram_dq_o  out  DATA_W  SRAM data to IOBUF I
  ram_dq_t  out  DATA_W  IOBUF T per lane; 1 = high-Z
  ram_ce_n, ram_oe_n, ram_we_n  out  1 each  active-low SRAM strobes
REQ-003 The block SHALL use one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-004 FSM states SHALL be IDLE, READ, WRITE, WREC, TURN.
REQ-005 req_ready SHALL be 1 only in IDLE with reset low; a request is accepted on an edge where req_valid && req_ready; req_we/addr/wdata are latched then; req_valid with req_ready low is ignored.
REQ-006 All ram_* outputs SHALL come straight from registers.
REQ-007 IDLE: ce_n=1, oe_n=1, we_n=1, dq_t all ones; ram_addr holds its last value.
REQ-008 READ: ce_n=0, oe_n=0, we_n=1, dq_t all ones, ram_addr=latched addr, for exactly RD_CYC cycles. At the final edge ram_dq_i is registered into rsp_rdata and the FSM returns to IDLE.
REQ-009 Read latency: rsp_valid SHALL be 1 for exactly one cycle, RD_CYC cycles after the accept edge, concurrent with IDLE. A new request may be accepted in that cycle, giving read throughput of one per RD_CYC+1 cycles.
REQ-010 WRITE: ce_n=0, oe_n=1, we_n=0, dq_t all zeros, dq_o=latched wdata, for exactly WR_CYC cycles.
REQ-011 WREC, one cycle: we_n=1, ce_n=0; dq_o, dq_t=0 and ram_addr held (data/address hold).
REQ-012 After WREC the FSM SHALL go to TURN for TA_CYC cycles (ce_n=1, oe_n=1, dq_t all ones), or straight to IDLE if TA_CYC=0. Writes produce no rsp_valid.
REQ-013 Invariants, every cycle: oe_n and we_n never both 0; dq_t=0 only while oe_n=1; ram_addr changes only in IDLE or on the accept edge.
REQ-014 The wait counter SHALL be sized to max(RD_CYC,WR_CYC,TA_CYC) and SHALL reload on every state entry; no wrap-around beyond terminal count.
REQ-015 Reset asserted in any state SHALL abort the access: on the next cycle the FSM is in IDLE with all strobes high, dq_t all ones, rsp_valid 0, and the in-flight access is discarded with no response.

Reset
REQ-016 While reset is high, the following SHALL hold from the first edge: state IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, ram_addr=0, ram_dq_o=0, ram_dq_t all ones, ram_ce_n=ram_oe_n=ram_we_n=1. req_ready SHALL be 1 on the first cycle after reset deasserts.

Verification (defaults unless stated; behavioural SRAM model on IOBUF)
REQ-017 Write 0x12345<-0xA5, then read 0x12345 -> rsp_rdata=0xA5; we_n low exactly 3 cycles; dq_t=0x00 during WRITE+WREC only.
REQ-018 Read accepted at edge k -> oe_n low cycles k+1..k+3, rsp_valid high in one cycle only, RD_CYC after k, req_ready=1 in that same cycle.
REQ-019 req_valid held high with 4 reads queued -> accepts every 4 cycles; 4 rsp_valid pulses with correct data.
REQ-020 Write immediately followed by read -> >=1 cycle with ce_n=1, dq_t=0xFF between we_n rising and oe_n falling; REQ-013 assertions hold for the whole test.
REQ-021 Reset pulsed in 2nd WRITE cycle -> next cycle we_n=1, ce_n=1, dq_t=0xFF, no rsp_valid; a following read of an untouched address returns the model's value.
REQ-022 DATA_W=16, ADDR_W=18, RD_CYC=1, WR_CYC=1, TA_CYC=0 -> 1000 random ops with random req_valid gaps match the reference model.
